apb_master_bridge: RTL and testbench

Single-outstanding APB3 master that converts a valid/ready command/response handshake into APB3 transfers on the shared 16-slot bus. Decodes the command address to a one-hot `PSEL`, sequences SETUP/ACCESS, honours `PREADY` wait states, and returns read data or errors (`PSLVERR`, decode miss, timeout) to the requester. It is the upstream driver of the APB3 bus that the APB monitor observes.

---
 rtl/apb_bridge_pkg.sv | 14 +
 rtl/apb_slot_decode.sv | 21 ++
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared FSM states, slot decode helper and defaults for the
// APB3 master bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} apb_state_e;

    localparam int SLOT_LSB_DEF = 12;
    localparam int TIMEOUT_DEF  = 256;

    function automatic logic [3:0] slot_of(input logic [63:0] addr, input int lsb = SLOT_LSB_DEF);
        return 4'(addr >> lsb);
    endfunction

endpackage

// File: rtl/apb_slot_decode.sv
// apb_slot_decode: maps an address to a one-hot PSEL vector, flagging slots
// beyond the populated range as a miss.
module apb_slot_decode
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_SLV  = 16,
    parameter int SLOT_LSB = SLOT_LSB_DEF
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [15:0]       o_onehot,
    output logic              o_miss
);

    logic [3:0] w_slot;

    assign w_slot   = slot_of(64'(i_addr), SLOT_LSB);
    assign o_miss   = {1'b0, w_slot} >= 5'(NUM_SLV);
    assign o_onehot = o_miss ? '0 : 16'(1) << w_slot;

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready to APB3 master with slot
// decode, wait-state handling and an optional ACCESS timeout.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_SLV  = 16,
    parameter int SLOT_LSB = SLOT_LSB_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic [15:0]       PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [15:0]      w_onehot;
    logic             w_miss;
    logic             w_abort;

    apb_slot_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SLOT_LSB(SLOT_LSB)
    ) u_dec (
        .i_addr  (cmd_addr),
        .o_onehot(w_onehot),
        .o_miss  (w_miss)
    );

    // Abort on the wait cycle that would bring the counter up to TIMEOUT.
    always_comb begin
        w_cnt_nxt = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);
        w_abort   = (TIMEOUT != 0) && !PREADY && (w_cnt_nxt == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (w_miss) begin
                            r_state     <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end else begin
                            r_state <= ST_SETUP;
                            r_cnt   <= '0;
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_write ? cmd_wdata : '0;
                            PSEL    <= w_onehot;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY || w_abort) begin
                        r_state     <= ST_RESP;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= !PREADY || PSLVERR;
                        rsp_timeout <= !PREADY;
                        rsp_rdata   <= (PREADY && !PWRITE && !PSLVERR) ? PRDATA : '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for apb_master_bridge with 8 slots
// and a 4-cycle timeout, driving a programmable APB slave model.
module tb_apb_master_bridge;

    localparam int NSLV = 8;
    localparam int TMO  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PREADY, PSLVERR;
    logic [15:0] PSEL;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        logic [15:0] psel;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          waits    = 0;
    logic        stuck    = 1'b0;
    logic [31:0] s_rdata  = '0;
    logic        s_err    = 1'b0;
    int          acc_cyc  = 0;
    logic [15:0] psel_h[64];
    logic        pen_h[64];
    logic [31:0] paddr_h[64];
    logic        pwrite_h[64];
    logic [31:0] pwdata_h[64];
    logic [15:0] dec_onehot;
    logic        dec_miss;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(NSLV), .SLOT_LSB(12), .TIMEOUT(TMO)
    ) dut (
        .PCLK(clk), .PRESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_slot_decode #(.ADDR_W(32), .NUM_SLV(NSLV), .SLOT_LSB(12)) u_ref (
        .i_addr(cmd_addr), .o_onehot(dec_onehot), .o_miss(dec_miss)
    );

    // Slave: PREADY rises after 'waits' ACCESS cycles unless stuck.
    always @(posedge clk) acc_cyc <= (PENABLE && !PREADY) ? acc_cyc + 1 : 0;
    assign PREADY  = PENABLE && !stuck && (acc_cyc >= waits);
    assign PRDATA  = s_rdata;
    assign PSLVERR = PENABLE && PREADY && s_err;

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input logic et);
        int   n = 0;
        exp_t e;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL accept_wait: cmd_ready=%b required 1", cmd_ready);
        end
        e.rdata = er;
        e.err   = ee;
        e.to    = et;
        e.psel  = dec_miss ? 16'h0 : dec_onehot;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            psel_h[k]   = PSEL;
            pen_h[k]    = PENABLE;
            paddr_h[k]  = PADDR;
            pwrite_h[k] = PWRITE;
            pwdata_h[k] = PWDATA;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL rsp_wait: rsp_valid absent after 39 cycles, required present");
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWDATA, PWRITE, PSEL, PENABLE} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b PSEL=%h PENABLE=%b PADDR=%h required all 0",
                     cmd_ready, rsp_valid, PSEL, PENABLE, PADDR);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int   lat;
        exp_t e;
        waits = 0; stuck = 1'b0; s_err = 1'b0; s_rdata = 32'hA5A5_A5A5;
        issue(1'b1, 32'h0000_3010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        wait_rsp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d required 3", lat); end
        checks++;
        if ({psel_h[1], pen_h[1]} !== {16'h0008, 1'b0}) begin
            failures++; $display("FAIL wr_setup: PSEL=%h PENABLE=%b required 0008/0", psel_h[1], pen_h[1]);
        end
        checks++;
        if (psel_h[1] !== e.psel) begin
            failures++; $display("FAIL wr_psel_ref: got %h required %h", psel_h[1], e.psel);
        end
        checks++;
        if ({pen_h[2], psel_h[2], pwrite_h[2], pwdata_h[2], paddr_h[2]} !== {1'b1, 16'h0008, 1'b1, 32'hDEAD_BEEF, 32'h0000_3010}) begin
            failures++;
            $display("FAIL wr_access: PENABLE=%b PSEL=%h PWRITE=%b PWDATA=%h PADDR=%h required 1/0008/1/deadbeef/00003010",
                     pen_h[2], psel_h[2], pwrite_h[2], pwdata_h[2], paddr_h[2]);
        end
        checks++;
        if ({psel_h[3], pen_h[3]} !== 17'h0) begin
            failures++; $display("FAIL wr_resp_bus: PSEL=%h PENABLE=%b required 0/0", psel_h[3], pen_h[3]);
        end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            failures++; $display("FAIL wr_rsp: rdata=%h err=%b to=%b required %h/%b/%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
        ack();
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            failures++; $display("FAIL wr_return_idle: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        int   lat;
        exp_t e;
        waits = 3; s_err = 1'b0; s_rdata = 32'h1234_5678;
        issue(1'b0, 32'h0000_5004, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
        wait_rsp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL rd_latency: got %0d required 6", lat); end
        checks++;
        if ({pwrite_h[1], pwdata_h[1]} !== 33'h0) begin
            failures++; $display("FAIL rd_setup_data: PWRITE=%b PWDATA=%h required 0/0", pwrite_h[1], pwdata_h[1]);
        end
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if ({pen_h[k], psel_h[k], paddr_h[k]} !== {1'b1, 16'h0020, 32'h0000_5004}) begin
                failures++; $display("FAIL rd_access_hold[%0d]: PENABLE=%b PSEL=%h PADDR=%h required 1/0020/00005004",
                                     k, pen_h[k], psel_h[k], paddr_h[k]);
            end
        end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            failures++; $display("FAIL rd_rsp: rdata=%h err=%b to=%b required %h/%b/%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
        ack();
    endtask

    task automatic test_slverr();
        int   lat;
        exp_t e;
        waits = 1; s_err = 1'b1; s_rdata = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_rsp(lat);
        e = sb.pop_front();
        s_err = 1'b0;
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL slverr_latency: got %0d required 4", lat); end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            failures++; $display("FAIL slverr_rsp: rdata=%h err=%b to=%b required %h/%b/%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
        ack();
    endtask

    task automatic test_miss();
        int   lat;
        exp_t e;
        waits = 0;
        issue(1'b0, 32'h0000_9000, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_rsp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL miss_latency: got %0d required 1", lat); end
        checks++;
        if ({psel_h[1], pen_h[1]} !== 17'h0 || e.psel !== 16'h0) begin
            failures++; $display("FAIL miss_no_bus: PSEL=%h PENABLE=%b ref=%h required 0/0/0", psel_h[1], pen_h[1], e.psel);
        end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            failures++; $display("FAIL miss_rsp: rdata=%h err=%b to=%b required %h/%b/%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
        ack();
    endtask

    task automatic test_timeout();
        int   lat;
        exp_t e;
        stuck = 1'b1; s_rdata = 32'h5555_AAAA;
        issue(1'b0, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_rsp(lat);
        e = sb.pop_front();
        stuck = 1'b0;
        checks++;
        if (lat !== TMO + 2) begin failures++; $display("FAIL to_latency: got %0d required %0d", lat, TMO + 2); end
        for (int k = 2; k <= TMO + 1; k++) begin
            checks++;
            if ({pen_h[k], psel_h[k]} !== {1'b1, e.psel}) begin
                failures++; $display("FAIL to_access[%0d]: PENABLE=%b PSEL=%h required 1/%h", k, pen_h[k], psel_h[k], e.psel);
            end
        end
        checks++;
        if ({psel_h[TMO + 2], pen_h[TMO + 2]} !== 17'h0) begin
            failures++; $display("FAIL to_bus_drop: PSEL=%h PENABLE=%b required 0/0", psel_h[TMO + 2], pen_h[TMO + 2]);
        end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
            failures++; $display("FAIL to_rsp: rdata=%h err=%b to=%b required %h/%b/%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
        ack();
    endtask

    task automatic test_rsp_hold();
        int   lat;
        exp_t e;
        waits = 0; s_rdata = 32'h0BAD_0BAD;
        issue(1'b0, 32'h0000_7004, 32'h0, 32'h0BAD_0BAD, 1'b0, 1'b0);
        wait_rsp(lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 1'b0, e.rdata, e.err, e.to}) begin
                failures++; $display("FAIL hold[%0d]: rsp_valid=%b cmd_ready=%b rdata=%h err=%b required 1/0/%h/%b",
                                     i, rsp_valid, cmd_ready, rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        ack();
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            failures++; $display("FAIL hold_release: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int nrsp = 0;
        waits = 0;
        cmd_write = 1'b1; cmd_addr = 32'h0000_6000; cmd_wdata = 32'h0000_0042;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (cmd_valid && cmd_ready) acc.push_back(c);
            if (rsp_valid) nrsp++;
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++;
        if (acc.size() != 3 || nrsp != 3) begin
            failures++; $display("FAIL b2b_count: accepts=%0d responses=%0d required 3/3", acc.size(), nrsp);
        end else begin
            checks++;
            if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
                failures++; $display("FAIL b2b_spacing: got %0d,%0d required 4,4", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        stuck = 1'b1;
        issue(1'b1, 32'h0000_4000, 32'h1111_2222, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (PENABLE !== 1'b1) begin
            failures++; $display("FAIL mid_in_access: PENABLE=%b required 1", PENABLE);
        end
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_front());
        checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PWDATA, PWRITE, PSEL, PENABLE} !== '0) begin
            failures++; $display("FAIL mid_reset_outputs: rsp_valid=%b PSEL=%h PENABLE=%b PADDR=%h PWDATA=%h required all 0",
                                 rsp_valid, PSEL, PENABLE, PADDR, PWDATA);
        end
        rst = 1'b0; stuck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL mid_no_rsp: rsp_valid cycles=%0d cmd_ready=%b required 0/1", seen, cmd_ready);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_miss();
        test_timeout();
        test_rsp_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
